// File: rtl/disp_pkg.sv
// Shared types and constants for the result display: FSM states, segment
// patterns and the double-dabble nibble adjust.
package disp_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam int unsigned NumBits = 8;

  // Active-low segments, bit 0 = a .. bit 6 = g.
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  localparam logic [9:0][6:0] SegGlyph = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [11:0] bcd_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// Signal bundle between the upstream ALU/bench and the result display.
interface result_display_if;
  logic [7:0] mag;
  logic       neg;
  logic       busy;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic       neg_q;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output mag, neg,
    input  busy, hund, tens, units, neg_q, seg, an
  );

  modport slave (
    input  mag, neg,
    output busy, hund, tens, units, neg_q, seg, an
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment decode of one digit with blank and minus overrides.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    if (minus) begin
      seg = SegMinus;
    end else if (!blank && digit < 4'd10) begin
      seg = SegGlyph[digit];
    end
  end

endmodule

// File: rtl/result_display.sv
// Binary-to-BCD conversion of a signed-magnitude result with a multiplexed
// four-digit seven-segment scan (sign, hundreds, tens, units).
module result_display
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             ar,
  result_display_if.slave  dbus
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [8:0]  last_q, last_d;
  logic        first_q, first_d;
  logic        sign_q, sign_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic        neg_out_q, neg_out_d;

  logic [PreW-1:0] pre_q;
  logic [1:0]      idx_q;

  logic [8:0]  pair;
  logic [19:0] shifted;

  assign pair    = {dbus.neg, dbus.mag};
  assign shifted = {bcd_adjust(scratch_q), shift_q} << 1;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q   <= StIdle;
      last_q    <= '0;
      first_q   <= 1'b1;
      sign_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      neg_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      first_q   <= first_d;
      sign_q    <= sign_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      neg_out_q <= neg_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    first_d   = first_q;
    sign_d    = sign_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    units_d   = units_q;
    neg_out_d = neg_out_q;
    case (state_q)
      StIdle: begin
        if (first_q || pair != last_q) begin
          shift_d   = dbus.mag;
          sign_d    = dbus.neg;
          last_d    = pair;
          scratch_d = '0;
          cnt_d     = '0;
          first_d   = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, shift_d} = shifted;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NumBits - 1)) state_d = StDone;
      end
      StDone: begin
        hund_d    = scratch_q[11:8];
        tens_d    = scratch_q[7:4];
        units_d   = scratch_q[3:0];
        neg_out_d = sign_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan prescaler: digit index only moves on prescaler wrap.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PreMax) begin
      pre_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  logic [3:0] an;
  logic [3:0] digit;
  logic       blank;
  logic       minus;
  logic [6:0] seg;

  always_comb begin
    an        = 4'b1111;
    an[idx_q] = 1'b0;
    digit     = units_q;
    blank     = 1'b0;
    minus     = 1'b0;
    case (idx_q)
      2'd0: digit = units_q;
      2'd1: begin
        digit = tens_q;
        blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        digit = hund_q;
        blank = (hund_q == 4'd0);
      end
      default: begin
        // Negative zero shows no minus sign.
        blank = 1'b1;
        minus = neg_out_q && ({hund_q, tens_q, units_q} != 12'd0);
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (digit),
    .blank (blank),
    .minus (minus),
    .seg   (seg)
  );

  assign dbus.busy  = (state_q != StIdle);
  assign dbus.hund  = hund_q;
  assign dbus.tens  = tens_q;
  assign dbus.units = units_q;
  assign dbus.neg_q = neg_out_q;
  assign dbus.seg   = seg;
  assign dbus.an    = an;

endmodule
